// File: rtl/seq_mul_radix4.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_radix4
// Purpose  : Iterative radix-4 unsigned multiplier, one 2-bit digit per clock,
//            with a start/done handshake. Define SEQ_MUL_EARLY_TERM_EN to
//            finish as soon as the remaining multiplier digits are all zero.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mul_radix4 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iStart,
    input  logic [WIDTH-1:0]     iA,
    input  logic [WIDTH-1:0]     iB,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [2*WIDTH-1:0]   oResult
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH/2 - 1);

    state_t                r_state;
    logic [2*WIDTH-1:0]    r_acc;
    logic [2*WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]      r_mplier;
    logic [CNT_W-1:0]      r_cnt;

    logic [2*WIDTH-1:0]    w_pp;
    logic [2*WIDTH-1:0]    w_sum;
    logic                  w_last;

    // Partial product selected by the current low multiplier digit.
    always_comb begin
        w_pp = '0;
        case (r_mplier[1:0])
            2'd0:    w_pp = '0;
            2'd1:    w_pp = r_mcand;
            2'd2:    w_pp = r_mcand << 1;
            default: w_pp = (r_mcand << 1) + r_mcand;
        endcase
    end

    assign w_sum = r_acc + w_pp;

`ifdef SEQ_MUL_EARLY_TERM_EN
    // Remaining digits all zero after this shift means the sum is final.
    assign w_last = (r_cnt == C_LAST_STEP) || (r_mplier[WIDTH-1:2] == '0);
`else
    assign w_last = (r_cnt == C_LAST_STEP);
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
            oResult  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        r_mcand  <= {{WIDTH{1'b0}}, iA};
                        r_mplier <= iB;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        oBusy    <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 2;
                    r_mplier <= r_mplier >> 2;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        oResult <= w_sum;
                        oDone   <= 1'b1;
                        oBusy   <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    oBusy   <= 1'b0;
                    oDone   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_radix4.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mul_radix4
// Purpose  : Directed and randomized check of seq_mul_radix4 against an
//            arithmetic reference (product and digit-count latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mul_radix4;

    localparam int W  = 16;
    localparam int RW = 2 * W;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          iStart;
    logic [W-1:0]  iA;
    logic [W-1:0]  iB;
    logic          oBusy;
    logic          oDone;
    logic [RW-1:0] oResult;

    int            checks = 0;
    int            errors = 0;
    logic [RW-1:0] prev_result;

    seq_mul_radix4 #(.WIDTH(W)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .iStart  (iStart),
        .iA      (iA),
        .iB      (iB),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oResult (oResult)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    // Cycles from accept to completion, derived from the digits of the multiplier.
    function automatic int exp_lat(input logic [W-1:0] b);
        int n;
        n = W / 2;
`ifdef SEQ_MUL_EARLY_TERM_EN
        n = 1;
        for (int d = 0; d < W/2; d++)
            if (b[2*d +: 2] != 2'b00) n = d + 1;
`endif
        return n;
    endfunction

    task automatic idle(input int n);
        iStart = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick;
            chk("idle_busy", oBusy, 1'b0);
            chk("idle_done", oDone, 1'b0);
            chk("idle_hold", oResult, prev_result);
        end
    endtask

    // Issue one operation; optionally pulse a stray iStart before edge accept+poke_at.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int poke_at);
        int            lat;
        logic [RW-1:0] prod;
        lat  = exp_lat(b);
        prod = RW'(a) * RW'(b);
        iStart = 1'b1;
        iA     = a;
        iB     = b;
        tick;
        iStart = 1'b0;
        iA     = W'($urandom);
        iB     = W'($urandom);
        chk("accept_busy", oBusy, 1'b1);
        chk("accept_done", oDone, 1'b0);
        chk("accept_hold", oResult, prev_result);
        for (int i = 1; i <= lat; i++) begin
            if (i == poke_at) begin
                iStart = 1'b1;
                iA     = 2;
                iB     = 2;
            end
            tick;
            iStart = 1'b0;
            if (i < lat) begin
                chk("run_busy", oBusy, 1'b1);
                chk("run_done", oDone, 1'b0);
                chk("run_hold", oResult, prev_result);
            end else begin
                chk("done_pulse", oDone, 1'b1);
                chk("done_busy", oBusy, 1'b0);
                chk("result", oResult, prod);
            end
        end
        prev_result = prod;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        Reset       = 1'b1;
        iStart      = 1'b0;
        iA          = '0;
        iB          = '0;
        prev_result = '0;
        repeat (2) @(negedge Clock);
        chk("reset_busy", oBusy, 1'b0);
        chk("reset_done", oDone, 1'b0);
        chk("reset_result", oResult, 0);
        Reset = 1'b0;
        idle(2);

        op(16'd3, 16'd5, 0);
        chk("3x5", oResult, 32'h0000000F);
        idle(1);
        op(16'hFFFF, 16'hFFFF, 0);
        chk("max_x_max", oResult, 32'hFFFE0001);
        idle(1);
        op(16'h1234, 16'h0000, 0);
        idle(1);

        // Stray start mid-run must be ignored.
        op(16'd7, 16'd9, 3);
        chk("ignored_start", oResult, 32'h0000003F);
        idle(2);

        // Back-to-back: second start issued during the DONE cycle.
        op(16'd3, 16'd5, 0);
        op(16'd10, 16'd10, 0);
        chk("back_to_back", oResult, 32'h00000064);
        idle(1);

        // Asynchronous reset aborts a running operation.
        iStart = 1'b1;
        iA     = 16'h00FF;
        iB     = 16'h0100;
        tick;
        iStart = 1'b0;
        repeat (3) tick;
        @(posedge Clock);
        #1 Reset = 1'b1;
        #1;
        chk("abort_busy", oBusy, 1'b0);
        chk("abort_done", oDone, 1'b0);
        chk("abort_result", oResult, 0);
        @(negedge Clock);
        Reset       = 1'b0;
        prev_result = '0;
        idle(6);
        op(16'd6, 16'd7, 0);
        chk("after_abort", oResult, 32'h0000002A);
        idle(1);

        op(16'd1, 16'hC000, 0);
        idle(1);

        for (int n = 0; n < 30; n++) begin
            ra = W'($urandom);
            rb = W'($urandom) >> $urandom_range(0, W);
            op(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_mul_radix4.md
Name: seq_mul_radix4

Overview:
- Iterative radix-4 unsigned multiplier, parametrised in operand width.
- Sequential successor of the combinational 16x16 mux-based multiplier. It retires one 2-bit multiplier digit per clock, using partial products of 0, A, 2A and 3A.
- Trades latency for area. It is started and completed with a start/done handshake, for use by datapath blocks that cannot afford a full array multiplier.

Parameters:
- WIDTH, 16, operand width in bits. Must be even and >= 4. Result width is 2*WIDTH.
- CNT_W, $clog2(WIDTH/2)+1, width of the internal step counter. Derived; do not override.

Ports:
- Clock  input  1  system clock. All state changes on posedge.
- Reset  input  1  asynchronous, active-high reset. Clears all state immediately.
- iStart  input  1  request pulse. Sampled on posedge; accepted only in IDLE or DONE.
- iA  input  WIDTH  multiplicand. Sampled at the accept edge only.
- iB  input  WIDTH  multiplier. Sampled at the accept edge only.
- oBusy  output  1  high while state is RUN.
- oDone  output  1  high for exactly one cycle when oResult is newly valid.
- oResult  output  2*WIDTH  product of the last completed operation. Held until the next completion.

Behaviour:
- Reset (async, any state): state=IDLE; oBusy=0; oDone=0; oResult=0; internal registers zeroed (acc, shifted multiplicand, multiplier shift register, step counter).
- States: IDLE, RUN, DONE. Encoded in 2 bits; the unused encoding returns to IDLE.
- IDLE/DONE, iStart=1 at edge k:
  - load mcand = iA zero-extended to 2*WIDTH;
  - load mplier = iB; acc=0; cnt=0;
  - state=RUN.
- IDLE, iStart=0: remain in IDLE.
- DONE, iStart=0: go to IDLE.
- Leaving DONE always drops oDone to 0.
- RUN, each edge:
  - digit = mplier[1:0];
  - pp = 0, mcand, mcand<<1 or (mcand<<1)+mcand for digit 0..3;
  - acc <= acc + pp, computed modulo 2^(2*WIDTH) (cannot overflow for valid operands);
  - mcand <= mcand<<2; mplier <= mplier>>2; cnt <= cnt+1.
- Last step (cnt == WIDTH/2-1 at the edge):
  - oResult <= acc + pp, from the same combinational sum;
  - state=DONE; oDone=1.
- Latency: oDone and the new oResult are visible WIDTH/2 cycles after the accept edge. Example: WIDTH=16 gives 8.
- Throughput: back-to-back operation is allowed. iStart in the DONE cycle is accepted, giving one op per WIDTH/2+1 cycles.
- iStart while in RUN is ignored: no restart and no error. iA/iB are don't-care outside the accept edge.
- oResult changes only at completion and at reset. It is stable through RUN of the following operation.
- Reset asserted mid-RUN aborts the operation. No oDone is produced and oResult=0.

Optional Feature:
- Macro: SEQ_MUL_EARLY_TERM_EN.
- Defined: the operation completes at the first RUN edge where the post-shift mplier is zero, or cnt == WIDTH/2-1, whichever comes first.
  - Latency = number of digits up to and including the highest nonzero digit of iB, minimum 1.
  - oResult, oDone timing and the DONE state behave as in the base design.
- Undefined: fixed latency of WIDTH/2 cycles. No early-exit logic is synthesised.

Test Plan:
- WIDTH=16, iA=3, iB=5, one-cycle iStart -> oBusy high 8 cycles; oDone pulses 1 cycle at accept+8; oResult=0x0000000F.
- iA=0xFFFF, iB=0xFFFF -> oResult=0xFFFE0001 at accept+8. Also iA=0x1234, iB=0 -> oResult=0.
- Start with iA=7, iB=9, then pulse iStart with iA=2, iB=2 at accept+3 -> second request ignored; oResult=0x3F; exactly one oDone.
- iStart held in the DONE cycle with iA=10, iB=10 -> oDone for 3*5=15, then a new op; next oDone 8 cycles later with oResult=0x64. oResult holds 0x0F in between.
- Assert Reset at accept+4 of 0x00FF*0x0100 -> on the same edge oBusy=0, oResult=0; no oDone; next op 6*7 returns 0x2A normally.
- SEQ_MUL_EARLY_TERM_EN defined: iB=5 -> oDone at accept+2, oResult=15. iB=0 -> oDone at accept+1. iB=0xC000 -> accept+8.
